alu_share_arb: RTL and testbench

//  Shares one alu instance between two requesters (e.g. main pipe and address/branch unit).

---
 rtl/alu_share_arb.sv | 172 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares a single alu between two requesters. A winner is picked in IDLE,
//   its operands and sel are registered onto the alu inputs (EXEC), the alu
//   result and zero flag are captured, and they are presented on one tagged
//   response channel (RESP) until the consumer takes them. Only one
//   operation is in flight at a time, so the best rate is one op every
//   3 cycles.
//
//   Build option: define ALU_ARB_RR_EN for round-robin arbitration on
//   contested cycles. Leave it undefined for fixed priority, where req0
//   always wins.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   reqN_valid/ready          requester N handshake (ready is combinational)
//   reqN_src1/src2/sel        requester N operands and alu op
//   alu_src1/src2/sel         registered operands to the alu
//   alu_res/alu_res_is_0      alu outputs
//   rsp_valid/ready           response handshake
//   rsp_id/res/zero           issuing requester, captured result and zero flag
module alu_share_arb #(
  parameter int SWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DWIDTH-1:0] req0_src1,
  input  logic [DWIDTH-1:0] req0_src2,
  input  logic [SWIDTH-1:0] req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DWIDTH-1:0] req1_src1,
  input  logic [DWIDTH-1:0] req1_src2,
  input  logic [SWIDTH-1:0] req1_sel,
  output logic [DWIDTH-1:0] alu_src1,
  output logic [DWIDTH-1:0] alu_src2,
  output logic [SWIDTH-1:0] alu_sel,
  input  logic [DWIDTH-1:0] alu_res,
  input  logic              alu_res_is_0,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DWIDTH-1:0] rsp_res,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] alu_src1_q, alu_src1_d;
  logic [DWIDTH-1:0] alu_src2_q, alu_src2_d;
  logic [SWIDTH-1:0] alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0] rsp_res_q, rsp_res_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              gnt0, gnt1;

  // Arbitration: grants only exist in IDLE, so ready is 0 elsewhere.
`ifdef ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        // Contested: the requester that did not win last time goes now.
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  // Reset to 1 so req0 wins the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    gnt0 = (state_q == IDLE) && req0_valid;
    gnt1 = (state_q == IDLE) && req1_valid && !req0_valid;
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_d     = state_q;
    alu_src1_d  = alu_src1_q;
    alu_src2_d  = alu_src2_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          alu_src1_d = gnt1 ? req1_src1 : req0_src1;
          alu_src2_d = gnt1 ? req1_src2 : req0_src2;
          alu_sel_d  = gnt1 ? req1_sel  : req0_sel;
          rsp_id_d   = gnt1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // The alu sees the registered operands this cycle; capture its output.
        rsp_res_d   = alu_res;
        rsp_zero_d  = alu_res_is_0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Return to IDLE even if a request is waiting; it is granted next cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_src1_q  <= '0;
      alu_src2_q  <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_src1_q  <= alu_src1_d;
      alu_src2_q  <= alu_src2_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign alu_src1  = alu_src1_q;
  assign alu_src2  = alu_src2_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
//   Bench for alu_share_arb. Provides a combinational alu behind the block,
//   runs directed operations with literal expectations, then random traffic
//   checked every cycle against a transaction-level model (busy flag, op age,
//   queue of expected responses). Honours ALU_ARB_RR_EN like the design.
module tb_alu_share_arb;

  localparam int SW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic [SW-1:0] req0_sel = '0, req1_sel = '0;
  logic [DW-1:0] alu_src1, alu_src2, alu_res;
  logic [SW-1:0] alu_sel;
  logic          alu_res_is_0;
  logic          rsp_valid, rsp_id, rsp_zero;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_res;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.SWIDTH(SW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_sel(req1_sel),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_res_is_0(alu_res_is_0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_zero(rsp_zero)
  );

  // Reference alu: AND=0 OR=1 ADD=2 SUB=6 SLT=7 (signed), anything else gives 0.
  function automatic logic [DW-1:0] alu_f(input logic [SW-1:0] s, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd7:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_res      = alu_f(alu_sel, alu_src1, alu_src2);
  assign alu_res_is_0 = (alu_res == '0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
  } rsp_t;

  rsp_t          exp_q[$];
  bit            m_busy = 0;
  int            m_age  = 0;
  bit            m_last = 1;
  logic [DW-1:0] m_s1 = '0, m_s2 = '0;
  logic [SW-1:0] m_sel = '0;

  always @(negedge clk) begin
    logic e_r0, e_r1, e_rv;
    rsp_t t;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
      chk("rst_alu_src1", alu_src1, 0);
      chk("rst_alu_src2", alu_src2, 0);
      chk("rst_alu_sel", alu_sel, 0);
      exp_q.delete();
      m_busy = 0; m_age = 0; m_last = 1;
      m_s1 = '0; m_s2 = '0; m_sel = '0;
    end else begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!m_busy) begin
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
          e_r0 = m_last;
          e_r1 = !m_last;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
`else
        e_r0 = req0_valid;
        e_r1 = req1_valid && !req0_valid;
`endif
      end
      e_rv = m_busy && (m_age >= 1);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("alu_src1", alu_src1, m_s1);
      chk("alu_src2", alu_src2, m_s2);
      chk("alu_sel", alu_sel, m_sel);
      if (e_rv && exp_q.size() > 0) begin
        chk("rsp_id", rsp_id, exp_q[0].id);
        chk("rsp_res", rsp_res, exp_q[0].res);
        chk("rsp_zero", rsp_zero, exp_q[0].zero);
      end
      // advance model over the coming edge
      if (m_busy) begin
        if (e_rv && rsp_ready) begin
          m_busy = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          m_age++;
        end
      end else if (e_r0 || e_r1) begin
        m_busy = 1;
        m_age  = 0;
        m_last = e_r1;
        m_s1   = e_r1 ? req1_src1 : req0_src1;
        m_s2   = e_r1 ? req1_src2 : req0_src2;
        m_sel  = e_r1 ? req1_sel  : req0_sel;
        t.id   = e_r1;
        t.res  = alu_f(m_sel, m_s1, m_s2);
        t.zero = (t.res == '0);
        exp_q.push_back(t);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [SW-1:0] s,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id) begin
      req1_valid = v; req1_sel = s; req1_src1 = a; req1_src2 = b;
    end else begin
      req0_valid = v; req0_sel = s; req0_src1 = a; req0_src2 = b;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One uncontested op from idle with rsp_ready high; fixed cycle timing.
  task automatic run_op(input bit id, input logic [SW-1:0] s, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] er, input bit ez);
    tick();
    rsp_ready = 1'b1;
    set_req(id, 1'b1, s, a, b);
    set_req(!id, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("op_ready_winner", id ? req1_ready : req0_ready, 1);
    chk("op_ready_other", id ? req0_ready : req1_ready, 0);
    tick();
    set_req(id, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("op_exec_rsp_valid", rsp_valid, 0);
    chk("op_exec_alu_sel", alu_sel, s);
    chk("op_exec_alu_src1", alu_src1, a);
    chk("op_exec_alu_src2", alu_src2, b);
    chk("op_exec_ready_other", id ? req0_ready : req1_ready, 0);
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_id", rsp_id, id);
    chk("op_rsp_res", rsp_res, er);
    chk("op_rsp_zero", rsp_zero, ez);
    @(negedge clk);
    chk("op_rsp_done", rsp_valid, 0);
  endtask

  initial begin
    int   got;
    bit   ids[2];
    logic [DW-1:0] rs[2];
    bit   a0, a1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_sel", alu_sel, 0);

    // Directed ops
    run_op(1'b0, 3'd2, 8'h05, 8'h03, 8'h08, 1'b0);  // ADD 5,3
    run_op(1'b1, 3'd6, 8'h07, 8'h07, 8'h00, 1'b1);  // SUB 7,7
    run_op(1'b0, 3'd7, 8'h03, 8'h09, 8'h01, 1'b0);  // SLT 3,9
    run_op(1'b0, 3'd3, 8'h55, 8'h22, 8'h00, 1'b1);  // unsupported sel
    run_op(1'b1, 3'd7, 8'hFE, 8'h01, 8'h01, 1'b0);  // SLT -2,1 signed

    // Contested from reset, both requesters keep presenting their op
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 3'd0, 8'hF0, 8'h3C);
    set_req(1'b1, 1'b1, 3'd1, 8'h0F, 8'hF0);
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[got] = rsp_id;
        rs[got]  = rsp_res;
        got++;
      end
    end
    chk("contest_count", got, 2);
    if (got == 2) begin
      chk("contest_first_id", ids[0], 0);
      chk("contest_first_res", rs[0], 8'h30);
`ifdef ALU_ARB_RR_EN
      chk("contest_second_id", ids[1], 1);
      chk("contest_second_res", rs[1], 8'hFF);
`else
      chk("contest_second_id", ids[1], 0);
      chk("contest_second_res", rs[1], 8'h30);
`endif
    end
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (4) tick();

    // Response stall: rsp_ready low for 5 RESP cycles with both requesters waiting
    do_reset();
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'd2, 8'h05, 8'h03);
    @(negedge clk);
    chk("stall_grant", req0_ready, 1);
    tick();
    set_req(1'b0, 1'b1, 3'd1, 8'h0F, 8'h30);
    set_req(1'b1, 1'b1, 3'd6, 8'h10, 8'h01);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_res", rsp_res, 8'h08);
      chk("stall_rsp_zero", rsp_zero, 0);
      chk("stall_req0_ready", req0_ready, 0);
      chk("stall_req1_ready", req1_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_handshake_ready0", req0_ready, 0);
    @(negedge clk);
`ifdef ALU_ARB_RR_EN
    chk("stall_next_grant1", req1_ready, 1);
`else
    chk("stall_next_grant0", req0_ready, 1);
`endif
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (4) tick();

    // Reset while in EXEC drops the op
    do_reset();
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 3'd2, 8'h01, 8'h01);
    @(negedge clk);
    chk("midrst_grant", req0_ready, 1);
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_src1", alu_src1, 0);
    chk("midrst_rsp_res", rsp_res, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    tick();
    set_req(1'b1, 1'b1, 3'd6, 8'h09, 8'h04);
    @(negedge clk);
    chk("midrst_idle_grant", req1_ready, 1);
    tick();
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (4) tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 249) == 0);
      if (!req0_valid || a0)
        set_req(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      if (!req1_valid || a1)
        set_req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
